// File: rtl/user_io_scan_chain.sv
// Serial scan front-end for an 8-bit user design: shifts a frame in, applies it to io_in,
// waits a settle time, captures io_out and shifts the captured word back out MSB first.
module user_io_scan_chain #(
    parameter int                 WIDTH         = 8,
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [WIDTH-1:0]   RESET_IO      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_in,
    input  logic             scan_valid,
    input  logic             scan_abort,
    output logic             scan_out,
    output logic             scan_out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [WIDTH-1:0] user_io_in,
    input  logic [WIDTH-1:0] user_io_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_UNLOAD
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [SW-1:0]    settle_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] user_io_in_q;
    logic             scan_out_valid_q;
    logic             busy_q;
    logic             frame_done_q;

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] cap_d;

    assign shift_d = {shift_q[WIDTH-2:0], scan_in};
    assign cap_d   = {cap_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            bit_cnt_q        <= '0;
            settle_q         <= '0;
            shift_q          <= '0;
            cap_q            <= '0;
            user_io_in_q     <= RESET_IO;
            scan_out_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Abort wins over everything, including an APPLY in flight.
            if (scan_abort) begin
                state_q          <= S_IDLE;
                bit_cnt_q        <= '0;
                scan_out_valid_q <= 1'b0;
                busy_q           <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_SHIFT: begin
                        if (scan_valid) begin
                            shift_q <= shift_d;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_APPLY;
                                busy_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                                state_q   <= S_SHIFT;
                            end
                        end
                    end
                    S_APPLY: begin
                        user_io_in_q <= shift_q;
                        if (SETTLE_CYCLES == 0) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            settle_q <= SETTLE_LOAD;
                            state_q  <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_q == '0) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            settle_q <= settle_q - SW'(1);
                        end
                    end
                    S_CAPTURE: begin
                        cap_q            <= user_io_out;
                        bit_cnt_q        <= '0;
                        scan_out_valid_q <= 1'b1;
                        state_q          <= S_UNLOAD;
                    end
                    S_UNLOAD: begin
                        cap_q <= cap_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q        <= '0;
                            scan_out_valid_q <= 1'b0;
                            busy_q           <= 1'b0;
                            frame_done_q     <= 1'b1;
                            state_q          <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q          <= S_IDLE;
                        bit_cnt_q        <= '0;
                        scan_out_valid_q <= 1'b0;
                        busy_q           <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gate with valid so a stale captured word never leaks onto the pin after an abort.
    assign scan_out       = scan_out_valid_q & cap_q[WIDTH-1];
    assign scan_out_valid = scan_out_valid_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign user_io_in     = user_io_in_q;

endmodule

// File: tb/tb_user_io_scan_chain.sv
// Two instances (settle 2 with inverting delayed stub, settle 0 with pass-through stub)
// driven frame by frame; expectations come from the documented latency rules.
module tb_user_io_scan_chain;

    localparam int         S_A   = 2;
    localparam int         S_B   = 0;
    localparam logic [7:0] RIO_A = 8'hA5;
    localparam logic [7:0] RIO_B = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scan_in = 1'b0;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic       scan_abort = 1'b0;

    logic       so_a, sov_a, busy_a, fd_a;
    logic       so_b, sov_b, busy_b, fd_b;
    logic [7:0] uin_a, uin_b, uout_a, uout_b;
    logic [7:0] dly1, dly2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] old_a = RIO_A;
    logic [7:0] old_b = RIO_B;

    always #5 clk = ~clk;

    // Stub A: io_out = ~io_in seen through two flops, so a short settle captures stale data.
    always @(posedge clk) begin
        dly1 <= uin_a;
        dly2 <= dly1;
    end
    assign uout_a = ~dly2;
    assign uout_b = uin_b;

    user_io_scan_chain #(.WIDTH(8), .SETTLE_CYCLES(S_A), .RESET_IO(RIO_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .scan_in(scan_in), .scan_valid(valid_a),
        .scan_abort(scan_abort), .scan_out(so_a), .scan_out_valid(sov_a),
        .busy(busy_a), .frame_done(fd_a), .user_io_in(uin_a), .user_io_out(uout_a)
    );

    user_io_scan_chain #(.WIDTH(8), .SETTLE_CYCLES(S_B), .RESET_IO(RIO_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .scan_in(scan_in), .scan_valid(valid_b),
        .scan_abort(scan_abort), .scan_out(so_b), .scan_out_valid(sov_b),
        .busy(busy_b), .frame_done(fd_b), .user_io_in(uin_b), .user_io_out(uout_b)
    );

    // gap_mode: 0 none, 1 alternate cycles, 2 random gaps.
    // busy_mode: 0 valid low, 1 random, 2 held high while the instance is busy.
    // abort_k: -1 none, else abort is driven into the edge following observation k.
    task automatic run_frame(input logic [7:0] val, input int gap_mode, input int busy_mode,
                             input int abort_k, input string name);
        logic [7:0] capv, oldv, uiov;
        logic       ebusy, esov, eso, efd, aborted, allowed, rv;
        logic       gbusy, gsov, gso, gfd;
        int         s, idx;
        for (int i = 7; i >= 0; i--) begin
            if (gap_mode == 1) begin
                valid_a = 1'b0; valid_b = 1'b0;
                @(posedge clk); @(negedge clk);
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 3)) begin
                    valid_a = 1'b0; valid_b = 1'b0;
                    scan_in = 1'($urandom_range(0, 1));
                    @(posedge clk); @(negedge clk);
                end
            end
            scan_in = val[i];
            valid_a = 1'b1; valid_b = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        for (int k = 0; k <= 12 + S_A; k++) begin
            for (int d = 0; d < 2; d++) begin
                s     = (d == 0) ? S_A : S_B;
                capv  = (d == 0) ? ~val : val;
                oldv  = (d == 0) ? old_a : old_b;
                gbusy = (d == 0) ? busy_a : busy_b;
                gsov  = (d == 0) ? sov_a : sov_b;
                gso   = (d == 0) ? so_a : so_b;
                gfd   = (d == 0) ? fd_a : fd_b;
                uiov  = (d == 0) ? uin_a : uin_b;
                aborted = (abort_k >= 0) && (k > abort_k);
                ebusy = !aborted && (k <= 9 + s);
                esov  = !aborted && (k >= 2 + s) && (k <= 9 + s);
                idx   = 7 - (k - 2 - s);
                eso   = 1'b0;
                if (esov) eso = capv[idx];
                efd   = !aborted && (k == 10 + s);
                checks++;
                if (gbusy !== ebusy) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d busy got %b exp %b", name, d, k, gbusy, ebusy);
                end
                checks++;
                if (gsov !== esov) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d scan_out_valid got %b exp %b", name, d, k, gsov, esov);
                end
                checks++;
                if (gso !== eso) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d scan_out got %b exp %b", name, d, k, gso, eso);
                end
                checks++;
                if (gfd !== efd) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d frame_done got %b exp %b", name, d, k, gfd, efd);
                end
                checks++;
                if (k == 0 || abort_k == 0) begin
                    if (uiov !== oldv) begin
                        errors++;
                        $display("FAIL %s dut%0d k=%0d user_io_in got %h exp %h", name, d, k, uiov, oldv);
                    end
                end else if (uiov !== val) begin
                    errors++;
                    $display("FAIL %s dut%0d k=%0d user_io_in got %h exp %h", name, d, k, uiov, val);
                end
            end
            scan_abort = (k == abort_k);
            scan_in    = 1'($urandom_range(0, 1));
            rv         = 1'($urandom_range(0, 1));
            allowed = (k <= 9 + S_A) && (abort_k < 0 || k <= abort_k);
            valid_a = allowed && (busy_mode == 2 || (busy_mode == 1 && rv));
            allowed = (k <= 9 + S_B) && (abort_k < 0 || k <= abort_k);
            valid_b = allowed && (busy_mode == 2 || (busy_mode == 1 && rv));
            @(posedge clk); @(negedge clk);
        end
        scan_abort = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        if (abort_k != 0) begin
            old_a = val;
            old_b = val;
        end
        $display("frame %s val=%h abort_k=%0d io_in_a=%h io_in_b=%h", name, val, abort_k, uin_a, uin_b);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (uin_a !== RIO_A || uin_b !== RIO_B) begin
            errors++;
            $display("FAIL reset user_io_in got %h/%h exp %h/%h", uin_a, uin_b, RIO_A, RIO_B);
        end
        checks++;
        if ({so_a, sov_a, busy_a, fd_a, so_b, sov_b, busy_b, fd_b} !== 8'h00) begin
            errors++;
            $display("FAIL reset outputs got %b exp 00000000",
                     {so_a, sov_a, busy_a, fd_a, so_b, sov_b, busy_b, fd_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released io_in_a=%h io_in_b=%h", uin_a, uin_b);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) begin
            scan_in = 1'($urandom_range(0, 1));
            valid_a = 1'b1; valid_b = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        valid_a = 1'b0; valid_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uin_a !== RIO_A || uin_b !== RIO_B) begin
            errors++;
            $display("FAIL midreset user_io_in got %h/%h exp %h/%h", uin_a, uin_b, RIO_A, RIO_B);
        end
        checks++;
        if ({sov_a, busy_a, sov_b, busy_b} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset valid/busy got %b exp 0000", {sov_a, busy_a, sov_b, busy_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        old_a = RIO_A;
        old_b = RIO_B;
        $display("midframe reset io_in_a=%h io_in_b=%h", uin_a, uin_b);
        run_frame(8'(($urandom_range(0, 255))), 0, 0, -1, "post_reset");
    endtask

    task automatic test_abort_shift();
        logic [7:0] v;
        v = 8'h6B;
        for (int i = 7; i >= 3; i--) begin
            scan_in = v[i];
            valid_a = 1'b1; valid_b = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        scan_abort = 1'b1; scan_in = 1'b1;
        @(posedge clk); @(negedge clk);
        scan_abort = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy_a, sov_a, fd_a, busy_b, sov_b, fd_b} !== 6'b000000) begin
                errors++;
                $display("FAIL abort_shift c=%0d busy/valid/done got %b exp 000000",
                         c, {busy_a, sov_a, fd_a, busy_b, sov_b, fd_b});
            end
            checks++;
            if (uin_a !== old_a || uin_b !== old_b) begin
                errors++;
                $display("FAIL abort_shift c=%0d user_io_in got %h/%h exp %h/%h",
                         c, uin_a, uin_b, old_a, old_b);
            end
            @(posedge clk); @(negedge clk);
        end
        $display("abort after 5 bits io_in_a=%h io_in_b=%h", uin_a, uin_b);
        run_frame(8'h12, 0, 0, -1, "after_abort");
    endtask

    task automatic test_basic();
        run_frame(8'h3C, 0, 0, -1, "basic_3c");
    endtask

    task automatic test_gaps();
        run_frame(8'h81, 1, 1, -1, "gaps_81");
    endtask

    task automatic test_held_valid();
        run_frame(8'hFF, 0, 2, -1, "held_ff");
        run_frame(8'h47, 0, 0, -1, "after_held");
    endtask

    task automatic test_abort_unload();
        run_frame(8'hD2, 0, 1, 4 + S_A, "abort_unload");
    endtask

    task automatic test_abort_apply();
        run_frame(8'h9E, 0, 1, 0, "abort_apply");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            run_frame(8'($urandom_range(0, 255)), 2, 1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_held_valid();
        test_abort_shift();
        test_abort_unload();
        test_abort_apply();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
